// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: sequencer states, SEW encodings and
// element/group decode helpers used by the ALU sequencer and writeback paths.
package vec_pkg;

  localparam int unsigned VLEN = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_EXEC,
    S_WB
  } seq_state_t;

  typedef enum logic [2:0] {
    SEW_E8  = 3'd0,
    SEW_E16 = 3'd1,
    SEW_E32 = 3'd2,
    SEW_E64 = 3'd3
  } vsew_t;

  function automatic logic sew_legal(input logic [2:0] vsew);
    return vsew <= SEW_E64;
  endfunction

  // Elements per 128-bit register.
  function automatic logic [4:0] epr_of(input logic [1:0] vsew);
    return 5'd16 >> vsew;
  endfunction

  // Registers in an LMUL group.
  function automatic logic [3:0] regs_of(input logic [1:0] lmul);
    return 4'd1 << lmul;
  endfunction

endpackage

// File: rtl/vec_tail_merge.sv
// Byte-granular tail merge: active element bytes from new_data, tail bytes
// from old_data. Purely combinational; shared with load/store writeback.
module vec_tail_merge
  import vec_pkg::*;
#(
  parameter int unsigned VL_W = 8
) (
  input  logic [2:0]      idx,
  input  logic [1:0]      vsew,
  input  logic [VL_W-1:0] vl,
  input  logic [VLEN-1:0] new_data,
  input  logic [VLEN-1:0] old_data,
  output logic [VLEN-1:0] merged
);

  logic [31:0] first_elem;

  assign first_elem = 32'(idx) * 32'(epr_of(vsew));

  always_comb begin
    merged = old_data;
    for (int unsigned b = 0; b < VLEN / 8; b++) begin
      if ((first_elem + (b >> vsew)) < 32'(vl))
        merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Issue sequencer in front of vec_alu: walks an LMUL group, reads operands,
// runs the ALU, tail-merges and writes back. Option: VEC_ALU_SEQ_TAIL_AGNOSTIC_EN.
module vec_alu_seq #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned VL_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [5:0]      cmd_opcode,
  input  logic [4:0]      cmd_vs1,
  input  logic [4:0]      cmd_vs2,
  input  logic [4:0]      cmd_vd,
  input  logic [2:0]      cmd_vsew,
  input  logic [1:0]      cmd_lmul,
  input  logic [VL_W-1:0] cmd_vl,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  output logic [4:0]      rf_raddr3,
  input  logic [VLEN-1:0] rf_rdata1,
  input  logic [VLEN-1:0] rf_rdata2,
  input  logic [VLEN-1:0] rf_rdata3,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [VLEN-1:0] rf_wdata,
  output logic            alu_run,
  output logic [5:0]      alu_opcode,
  output logic [VLEN-1:0] alu_vs1,
  output logic [VLEN-1:0] alu_vs2,
  output logic [2:0]      alu_vsew,
  input  logic [VLEN-1:0] alu_vd,
  input  logic            alu_done,
  output logic            busy,
  output logic            err
);
  import vec_pkg::*;

  seq_state_t      state, state_d;
  logic [2:0]      idx;
  logic [5:0]      opcode_q;
  logic [4:0]      vs1_q, vs2_q, vd_q;
  logic [1:0]      vsew_q, lmul_q;
  logic [VL_W-1:0] vl_q;
  logic [VLEN-1:0] op1_q, op2_q, res_q;
  logic [VLEN-1:0] old_vd;
  logic [VLEN-1:0] merged;
  logic            err_q;
  logic            accept;
  logic            wb_last;

  assign accept = cmd_valid && cmd_ready;

  // Last register of the group, or everything beyond this register is tail.
  assign wb_last = ({1'b0, idx} == regs_of(lmul_q) - 4'd1) ||
                   ((32'(idx) + 32'd1) * 32'(epr_of(vsew_q)) >= 32'(vl_q));

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept && sew_legal(cmd_vsew))
          // vl=0 passes through WB for one cycle with the write suppressed.
          state_d = (cmd_vl == '0) ? S_WB : S_READ;
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_EXEC;
      S_EXEC:  if (alu_done) state_d = S_WB;
      S_WB:    state_d = wb_last ? S_IDLE : S_READ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      opcode_q <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      vsew_q   <= '0;
      lmul_q   <= '0;
      vl_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            opcode_q <= cmd_opcode;
            vs1_q    <= cmd_vs1;
            vs2_q    <= cmd_vs2;
            vd_q     <= cmd_vd;
            vsew_q   <= cmd_vsew[1:0];
            lmul_q   <= cmd_lmul;
            vl_q     <= cmd_vl;
            idx      <= '0;
            err_q    <= !sew_legal(cmd_vsew);
          end
        end
        S_LATCH: begin
          op1_q <= rf_rdata1;
          op2_q <= rf_rdata2;
        end
        S_EXEC: if (alu_done) res_q <= alu_vd;
        S_WB:   if (!wb_last) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef VEC_ALU_SEQ_TAIL_AGNOSTIC_EN
  assign old_vd    = '1;
  assign rf_raddr3 = '0;
`else
  logic [VLEN-1:0] old_q;

  always_ff @(posedge clk) begin
    if (reset)
      old_q <= '0;
    else if (state == S_LATCH)
      old_q <= rf_rdata3;
  end

  assign old_vd    = old_q;
  assign rf_raddr3 = (state == S_READ) ? vd_q + 5'(idx) : '0;
`endif

  vec_tail_merge #(
    .VL_W(VL_W)
  ) u_merge (
    .idx     (idx),
    .vsew    (vsew_q),
    .vl      (vl_q),
    .new_data(res_q),
    .old_data(old_vd),
    .merged  (merged)
  );

  assign cmd_ready  = (state == S_IDLE) && !reset;
  assign busy       = (state != S_IDLE);
  assign err        = err_q;
  assign rf_raddr1  = (state == S_READ) ? vs1_q + 5'(idx) : '0;
  assign rf_raddr2  = (state == S_READ) ? vs2_q + 5'(idx) : '0;
  assign rf_we      = (state == S_WB) && (vl_q != '0) && !reset;
  assign rf_waddr   = rf_we ? vd_q + 5'(idx) : '0;
  assign rf_wdata   = rf_we ? merged : '0;
  assign alu_run    = (state == S_EXEC);
  assign alu_opcode = opcode_q;
  assign alu_vs1    = op1_q;
  assign alu_vs2    = op2_q;
  assign alu_vsew   = {1'b0, vsew_q};

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq with a behavioural register file and ALU.
module tb_vec_alu_seq;

  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_VS1  = 6'b000001;
  localparam logic [5:0] OP_VS2  = 6'b000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_opcode;
  logic [4:0]   cmd_vs1, cmd_vs2, cmd_vd;
  logic [2:0]   cmd_vsew;
  logic [1:0]   cmd_lmul;
  logic [7:0]   cmd_vl;
  logic [4:0]   rf_raddr1, rf_raddr2, rf_raddr3;
  logic [127:0] rf_rdata1, rf_rdata2, rf_rdata3;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [127:0] rf_wdata;
  logic         alu_run;
  logic [5:0]   alu_opcode;
  logic [127:0] alu_vs1, alu_vs2;
  logic [2:0]   alu_vsew;
  logic [127:0] alu_vd;
  logic         alu_done;
  logic         busy;
  logic         err;

  vec_alu_seq #(.VLEN(128), .VL_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
    .cmd_vsew(cmd_vsew), .cmd_lmul(cmd_lmul), .cmd_vl(cmd_vl),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_vs1(alu_vs1),
    .alu_vs2(alu_vs2), .alu_vsew(alu_vsew), .alu_vd(alu_vd),
    .alu_done(alu_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [4:0]   addr;
    logic [127:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Register file: one-cycle registered read, write on the clock edge.
  logic [127:0] rf [32];
  always @(posedge clk) begin
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
    rf_rdata3 <= rf[rf_raddr3];
    if (rf_we) rf[rf_waddr] = rf_wdata;
  end

  // Behavioural ALU: done after alu_k cycles of alu_run unless withheld.
  int unsigned alu_k = 1;
  bit          alu_hold = 1'b0;
  int unsigned alu_cnt = 0;
  initial begin
    alu_done = 1'b0;
    alu_vd   = '0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (alu_run && !alu_hold) begin
        if (alu_cnt == alu_k) begin
          alu_done = 1'b1;
          alu_cnt  = 0;
          case (alu_opcode)
            OP_AND:  alu_vd = alu_vs1 & alu_vs2;
            OP_VS1:  alu_vd = alu_vs1;
            default: alu_vd = alu_vs2;
          endcase
        end else begin
          alu_cnt++;
        end
      end else begin
        alu_cnt = 0;
      end
    end
  end

  // Write monitor: every rf_we must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [127:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Returns at the negedge of the cycle following the handshake edge.
  task automatic issue(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [2:0] sew, input logic [1:0] lm,
                       input logic [7:0] vl, input bit hold);
    int unsigned n;
    @(negedge clk);
    cmd_opcode = op; cmd_vs1 = s1; cmd_vs2 = s2; cmd_vd = d;
    cmd_vsew = sew; cmd_lmul = lm; cmd_vl = vl; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got cmd_ready 0, required 1");
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 128'(busy), 128'd0);
    chk({name, "_sb_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  localparam logic [127:0] V1    = 128'habcdabcdbeefbeef1234567887654321;
  localparam logic [127:0] V2    = 128'h8765432112345678beefbeefabcdabcd;
  localparam logic [127:0] VAND  = 128'h83450301122416681224166883450301;
  localparam logic [127:0] T_SRC = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] GA    = 128'h11112222333344445555666677778888;
  localparam logic [127:0] GB    = 128'h9999aaaabbbbccccddddeeeeffff0000;
  localparam logic [127:0] GO0   = 128'hdeadbeef00000001cafef00d00000002;
  localparam logic [127:0] GW0   = 128'hdeadbeef00000001ddddeeeeffff0000;
`ifdef VEC_ALU_SEQ_TAIL_AGNOSTIC_EN
  localparam logic [127:0] T_EXP = 128'hffffffff89abcdeffedcba9876543210;
`else
  localparam logic [127:0] T_EXP = 128'h5555555589abcdeffedcba9876543210;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bit          ready_bad;

    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = V1; rf[2] = V2; rf[3] = 128'h0f0f;
    rf[5] = T_SRC; rf[6] = {16{8'h55}};
    rf[10] = GA; rf[11] = GB; rf[0] = GO0;
    for (int i = 0; i < 4; i++) rf[12 + i] = {16{8'(8'ha0 + i)}};

    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_vs1 = '0; cmd_vs2 = '0;
    cmd_vd = '0; cmd_vsew = '0; cmd_lmul = '0; cmd_vl = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 128'({cmd_ready, rf_raddr1, rf_raddr2, rf_raddr3, rf_we, rf_waddr,
                            alu_run, alu_opcode, alu_vsew, busy, err}), 128'd0);
    chk("reset_data", rf_wdata | alu_vs1 | alu_vs2, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 128'(cmd_ready), 128'd1);

    // AND, full register, plus handshake-to-write latency 3+k from cycle 1.
    alu_k = 1;
    push(5'd3, VAND);
    issue(OP_AND, 5'd1, 5'd2, 5'd3, 3'd3, 2'd0, 8'd2, 1'b0);
    n = 0;
    while (!rf_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("and_latency", 128'(n), 128'd4);
    wait_idle("and");

    // Tail merge on e32 with vl=3.
    alu_k = 0;
    push(5'd6, T_EXP);
    issue(OP_VS2, 5'd4, 5'd5, 5'd6, 3'd2, 2'd0, 8'd3, 1'b0);
    wait_idle("tail");

    // Group skip and vd index wrap.
    alu_k = 2;
    push(5'd31, GA);
    issue(OP_VS2, 5'd20, 5'd10, 5'd31, 3'd3, 2'd1, 8'd2, 1'b0);
    wait_idle("grp_l2_vl2");
    push(5'd31, GA);
    push(5'd0, GW0);
    issue(OP_VS2, 5'd20, 5'd10, 5'd31, 3'd3, 2'd1, 8'd3, 1'b0);
    wait_idle("grp_l2_vl3");
    push(5'd31, GA);
    push(5'd0, GW0);
    issue(OP_VS2, 5'd20, 5'd10, 5'd31, 3'd3, 2'd3, 8'd3, 1'b0);
    wait_idle("grp_l8_vl3");

    // vl=0: one busy cycle, no write.
    issue(OP_VS2, 5'd1, 5'd2, 5'd9, 3'd0, 2'd0, 8'd0, 1'b0);
    chk("vl0_busy", 128'(busy), 128'd1);
    @(negedge clk);
    chk("vl0_idle", 128'(busy), 128'd0);
    chk("vl0_sb_empty", 128'(exp_q.size()), 128'd0);

    // Illegal vsew: err pulse, never busy.
    issue(OP_VS2, 5'd1, 5'd2, 5'd9, 3'd5, 2'd0, 8'd4, 1'b0);
    chk("bad_sew_err", 128'({err, busy}), 128'b10);
    @(negedge clk);
    chk("bad_sew_after", 128'({err, busy}), 128'b00);

    // Reset while EXEC waits on a withheld done.
    alu_hold = 1'b1;
    issue(OP_VS2, 5'd1, 5'd2, 5'd7, 3'd3, 2'd0, 8'd2, 1'b0);
    n = 0;
    while (!alu_run && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_exec_reached", 128'(alu_run), 128'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", 128'({cmd_ready, rf_raddr1, rf_raddr2, rf_raddr3, rf_we, rf_waddr,
                              alu_run, alu_opcode, alu_vsew, busy, err}), 128'd0);
    chk("rst_mid_data", rf_wdata | alu_vs1 | alu_vs2, 128'd0);
    reset = 1'b0;
    alu_hold = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 128'({cmd_ready, busy}), 128'b10);
    repeat (3) @(negedge clk);
    chk("rst_mid_sb_empty", 128'(exp_q.size()), 128'd0);

    // Backpressure: cmd_valid held through a 4-register group, k=3.
    alu_k = 3;
    for (int i = 0; i < 4; i++) push(5'(16 + i), {16{8'(8'ha0 + i)}});
    push(5'd25, V1);
    issue(OP_VS2, 5'd20, 5'd12, 5'd16, 3'd0, 2'd2, 8'd64, 1'b1);
    cmd_opcode = OP_VS1; cmd_vs1 = 5'd1; cmd_vs2 = 5'd2; cmd_vd = 5'd25;
    cmd_vsew = 3'd3; cmd_lmul = 2'd0; cmd_vl = 8'd2;
    ready_bad = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      if (cmd_ready) ready_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("bp_ready_while_busy", 128'(ready_bad), 128'd0);
    chk("bp_first_idle", 128'({cmd_ready, busy}), 128'b10);
    @(negedge clk);
    chk("bp_second_accepted", 128'(busy), 128'd1);
    cmd_valid = 1'b0;
    wait_idle("bp");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
